// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage with operand forwarding, the RV32I ALU and the EX/MEM register.
// Define RV32M_EN to build in the iterative multiply/divide unit and its stall request.
package riscv_pkg;
   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] xlen_t;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_AND    = 5'd2,
      ALU_OR     = 5'd3,
      ALU_XOR    = 5'd4,
      ALU_SLT    = 5'd5,
      ALU_SLTU   = 5'd6,
      ALU_SLL    = 5'd7,
      ALU_SRL    = 5'd8,
      ALU_SRA    = 5'd9,
      ALU_LUI    = 5'd10,
      ALU_MUL    = 5'd11,
      ALU_MULH   = 5'd12,
      ALU_MULHSU = 5'd13,
      ALU_MULHU  = 5'd14,
      ALU_DIV    = 5'd15,
      ALU_DIVU   = 5'd16,
      ALU_REM    = 5'd17,
      ALU_REMU   = 5'd18
   } alu_op_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    alu_src;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      logic    mem_to_reg;
   } ctrl_t;

   typedef struct packed {
      xlen_t      rs1_data;
      xlen_t      rs2_data;
      xlen_t      imm;
      logic [4:0] rd;
      ctrl_t      ctrl;
   } id_ex_t;

   typedef struct packed {
      xlen_t      alu_result;
      xlen_t      rs2_data;
      logic [4:0] rd;
      ctrl_t      ctrl;
   } ex_mem_t;
endpackage

module ex_stage
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  id_ex_t     id_ex_in,
   input  logic [1:0] fwd_a_sel,
   input  logic [1:0] fwd_b_sel,
   input  xlen_t      wb_data,
   input  logic       stall,
   input  logic       flush,
   output logic       ex_stall_req,
   output ex_mem_t    ex_mem_out
);

   xlen_t op_a;
   xlen_t fwd_b;
   xlen_t op_b;
   xlen_t alu_result;

   // Reserved select code 11 falls back to the ID/EX operand.
   always_comb begin
      case (fwd_a_sel)
         2'b01:   op_a = ex_mem_out.alu_result;
         2'b10:   op_a = wb_data;
         default: op_a = id_ex_in.rs1_data;
      endcase
      case (fwd_b_sel)
         2'b01:   fwd_b = ex_mem_out.alu_result;
         2'b10:   fwd_b = wb_data;
         default: fwd_b = id_ex_in.rs2_data;
      endcase
      op_b = id_ex_in.ctrl.alu_src ? id_ex_in.imm : fwd_b;
   end

   always_comb begin
      alu_result = '0;
      case (id_ex_in.ctrl.alu_op)
         ALU_ADD:  alu_result = op_a + op_b;
         ALU_SUB:  alu_result = op_a - op_b;
         ALU_AND:  alu_result = op_a & op_b;
         ALU_OR:   alu_result = op_a | op_b;
         ALU_XOR:  alu_result = op_a ^ op_b;
         ALU_SLT:  alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_result = {31'd0, (op_a < op_b)};
         ALU_SLL:  alu_result = op_a << op_b[4:0];
         ALU_SRL:  alu_result = op_a >> op_b[4:0];
         ALU_SRA:  alu_result = $signed(op_a) >>> op_b[4:0];
         ALU_LUI:  alu_result = op_b;
         default:  alu_result = '0;
      endcase
   end

`ifdef RV32M_EN
   typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} m_state_t;

   m_state_t    state;
   m_state_t    state_next;
   alu_op_t     m_op;
   xlen_t       m_a;
   xlen_t       m_b;
   xlen_t       m_rs2;
   logic [4:0]  m_rd;
   ctrl_t       m_ctrl;
   logic [4:0]  count;
   xlen_t       acc;
   xlen_t       quot;
   logic        in_is_m;
   logic        in_is_div;
   logic        in_div_signed;
   logic        m_is_mul;
   logic        m_div_signed;
   logic        a_signed;
   logic        b_signed;
   logic        div_by_zero;
   logic        div_overflow;
   xlen_t       divisor_mag;
   xlen_t       q_fixed;
   xlen_t       r_fixed;
   xlen_t       m_result;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] product;
   logic [32:0] shifted;
   logic [32:0] trial;

   // acc holds the partial remainder (or product high word), quot the shifting dividend/quotient.
   always_comb begin
      in_is_m       = id_ex_in.ctrl.alu_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                                   ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      in_is_div     = id_ex_in.ctrl.alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      in_div_signed = id_ex_in.ctrl.alu_op inside {ALU_DIV, ALU_REM};
      m_is_mul      = m_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
      m_div_signed  = m_op inside {ALU_DIV, ALU_REM};
      a_signed      = m_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU};
      b_signed      = m_op inside {ALU_MUL, ALU_MULH};
      a_ext         = {{32{a_signed & m_a[31]}}, m_a};
      b_ext         = {{32{b_signed & m_b[31]}}, m_b};
      product       = a_ext * b_ext;
      divisor_mag   = (m_div_signed && m_b[31]) ? -m_b : m_b;
      shifted       = {acc, quot[31]};
      trial         = shifted - {1'b0, divisor_mag};
      div_by_zero   = (m_b == '0);
      div_overflow  = m_div_signed && (m_a == 32'h8000_0000) && (m_b == 32'hFFFF_FFFF);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= M_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         M_IDLE:  if (in_is_m) state_next = M_BUSY;
         M_BUSY:  if (m_is_mul || count == 5'd0) state_next = M_DONE;
         default: state_next = M_IDLE;
      endcase
      if (stall)
         state_next = state;
      if (flush)
         state_next = M_IDLE;
   end

   always_comb begin
      ex_stall_req = 1'b0;
      m_result     = '0;
      if (!rst)
         ex_stall_req = (state == M_BUSY) || (state == M_IDLE && in_is_m);
      q_fixed = (m_div_signed && (m_a[31] ^ m_b[31])) ? -quot : quot;
      r_fixed = (m_div_signed && m_a[31]) ? -acc : acc;
      case (m_op)
         ALU_MUL:                         m_result = quot;
         ALU_MULH, ALU_MULHSU, ALU_MULHU: m_result = acc;
         ALU_DIV, ALU_DIVU: m_result = div_by_zero  ? 32'hFFFF_FFFF :
                                       div_overflow ? 32'h8000_0000 : q_fixed;
         ALU_REM, ALU_REMU: m_result = div_by_zero  ? m_a :
                                       div_overflow ? 32'd0 : r_fixed;
         default:                         m_result = '0;
      endcase
   end

   // Restoring division: one quotient bit per BUSY cycle, counter 31 down to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_op   <= ALU_ADD;
         m_a    <= '0;
         m_b    <= '0;
         m_rs2  <= '0;
         m_rd   <= '0;
         m_ctrl <= '0;
         count  <= '0;
         acc    <= '0;
         quot   <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (!stall) begin
         case (state)
            M_IDLE: begin
               if (in_is_m) begin
                  m_op   <= id_ex_in.ctrl.alu_op;
                  m_a    <= op_a;
                  m_b    <= op_b;
                  m_rs2  <= fwd_b;
                  m_rd   <= id_ex_in.rd;
                  m_ctrl <= id_ex_in.ctrl;
                  count  <= in_is_div ? 5'd31 : 5'd0;
                  acc    <= '0;
                  quot   <= (in_div_signed && op_a[31]) ? -op_a : op_a;
               end
            end
            M_BUSY: begin
               if (m_is_mul) begin
                  acc  <= product[63:32];
                  quot <= product[31:0];
               end else begin
                  acc  <= trial[32] ? shifted[31:0] : trial[31:0];
                  quot <= {quot[30:0], ~trial[32]};
                  if (count != 5'd0)
                     count <= count - 5'd1;
               end
            end
            default: ;
         endcase
      end
   end
`else
   assign ex_stall_req = 1'b0;
`endif

   // A pending M operation turns every unstalled cycle into a bubble until its result is ready.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ex_mem_out <= '0;
      end else if (!stall) begin
`ifdef RV32M_EN
         if (ex_stall_req)
            ex_mem_out <= '0;
         else if (state == M_DONE)
            ex_mem_out <= ex_mem_t'{m_result, m_rs2, m_rd, m_ctrl};
         else
`endif
            ex_mem_out <= ex_mem_t'{alu_result, fwd_b, id_ex_in.rd, id_ex_in.ctrl};
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against an arithmetic reference model.
// Multiply/divide checks are built only when RV32M_EN is defined; otherwise the disabled behaviour is checked.
module tb_ex_stage;
   import riscv_pkg::*;

   logic       clk;
   logic       rst;
   logic       stall;
   logic       flush;
   id_ex_t     id_ex_in;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   xlen_t      wb_data;
   logic       ex_stall_req;
   ex_mem_t    ex_mem_out;

   int    checks = 0;
   int    errors = 0;
   xlen_t exp_res;

   alu_op_t single_ops [11] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
                                ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI};

   ex_stage dut (
      .clk          (clk),
      .rst          (rst),
      .id_ex_in     (id_ex_in),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .wb_data      (wb_data),
      .stall        (stall),
      .flush        (flush),
      .ex_stall_req (ex_stall_req),
      .ex_mem_out   (ex_mem_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference results straight from the RV32IM definitions using 64-bit integer arithmetic.
   function automatic xlen_t ref_alu(input alu_op_t op, input xlen_t a, input xlen_t b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      case (op)
         ALU_ADD:    return a + b;
         ALU_SUB:    return a - b;
         ALU_AND:    return a & b;
         ALU_OR:     return a | b;
         ALU_XOR:    return a ^ b;
         ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
         ALU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
         ALU_SLL:    return a << (b % 32);
         ALU_SRL:    return a >> (b % 32);
         ALU_SRA:    return xlen_t'(sa >>> (b % 32));
         ALU_LUI:    return b;
         ALU_MUL:    begin p = sa * sb; return p[31:0];  end
         ALU_MULH:   begin p = sa * sb; return p[63:32]; end
         ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
         ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
         ALU_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return xlen_t'(sa / sb);
         end
         ALU_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : xlen_t'(ua / ub);
         ALU_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return xlen_t'(sa % sb);
         end
         ALU_REMU:   return (b == 32'd0) ? a : xlen_t'(ua % ub);
         default:    return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input alu_op_t op, input xlen_t rs1, input xlen_t rs2, input xlen_t imm,
                                input logic src, input logic [4:0] rd, input logic [1:0] fa,
                                input logic [1:0] fb, input xlen_t wb);
      id_ex_in.rs1_data      = rs1;
      id_ex_in.rs2_data      = rs2;
      id_ex_in.imm           = imm;
      id_ex_in.rd            = rd;
      id_ex_in.ctrl.alu_op   = op;
      id_ex_in.ctrl.alu_src  = src;
      {id_ex_in.ctrl.mem_read, id_ex_in.ctrl.mem_write,
       id_ex_in.ctrl.reg_write, id_ex_in.ctrl.mem_to_reg} = 4'($urandom);
      fwd_a_sel = fa;
      fwd_b_sel = fb;
      wb_data   = wb;
      #1;
   endtask

   task automatic driveBubble();
      id_ex_in  = '0;
      fwd_a_sel = 2'd0;
      fwd_b_sel = 2'd0;
      wb_data   = '0;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

`ifdef RV32M_EN
   alu_op_t m_ops [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

   // Issues one M op, optionally stalls mid-operation or in the result cycle, and checks latency and result.
   task automatic runMOp(input alu_op_t op, input xlen_t a, input xlen_t b, input int stall_at,
                         input int stall_len, input int done_stall, input string tag);
      int         n;
      int         base;
      logic       bubbles_ok;
      xlen_t      expv;
      logic [4:0] rd;
      ctrl_t      ctl;
      expv = ref_alu(op, a, b);
      base = (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) ? 2 : 33;
      rd   = 5'($urandom_range(1, 31));
      applyStimulus(op, a, b, $urandom, 1'b0, rd, 2'd0, 2'd0, $urandom);
      ctl = id_ex_in.ctrl;
      n = 0;
      bubbles_ok = 1'b1;
      while (ex_stall_req === 1'b1 && n < 200) begin
         n++;
         if (n == stall_at) stall = 1'b1;
         if (n == stall_at + stall_len) stall = 1'b0;
         tick();
         if (ex_mem_out !== '0) bubbles_ok = 1'b0;
      end
      stall = 1'b0;
      checkOutput({tag, " stall cycles"}, 96'(n), 96'(base + stall_len));
      checkOutput({tag, " bubbles"}, 96'(bubbles_ok), 96'd1);
      driveBubble();
      for (int k = 0; k < done_stall; k++) begin
         stall = 1'b1;
         tick();
         checkOutput({tag, " held in done"}, ex_mem_out.alu_result, 96'd0);
         checkOutput({tag, " no req in done"}, 96'(ex_stall_req), 96'd0);
      end
      stall = 1'b0;
      tick();
      checkOutput({tag, " result"}, ex_mem_out.alu_result, expv);
      checkOutput({tag, " rd/ctrl/rs2"}, {ex_mem_out.rd, ex_mem_out.ctrl, ex_mem_out.rs2_data},
                  {rd, ctl, b});
      exp_res = expv;
   endtask

   task automatic abortMOp(input alu_op_t op, input int at, input logic use_rst, input string tag);
      applyStimulus(op, 32'd1000, 32'd7, 32'd0, 1'b0, 5'd3, 2'd0, 2'd0, 32'd0);
      for (int k = 1; k < at; k++) tick();
      checkOutput({tag, " busy before abort"}, 96'(ex_stall_req), 96'd1);
      if (use_rst) rst = 1'b1;
      else flush = 1'b1;
      driveBubble();
      tick();
      rst   = 1'b0;
      flush = 1'b0;
      #1;
      checkOutput({tag, " ex_mem cleared"}, ex_mem_out, 96'd0);
      checkOutput({tag, " req dropped"}, 96'(ex_stall_req), 96'd0);
      tick();
      checkOutput({tag, " still idle"}, 96'(ex_stall_req), 96'd0);
      exp_res = '0;
   endtask
`endif

   initial begin
      alu_op_t    op;
      xlen_t      a_raw, b_raw, imm, wb, opa, fb_val, opb, expv;
      logic [1:0] fa, fb;
      logic       src;
      logic [4:0] rd;

      rst   = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      applyStimulus(ALU_DIV, 32'd50, 32'd5, 32'd0, 1'b0, 5'd9, 2'd0, 2'd0, 32'd0);
      tick();
      tick();
      checkOutput("reset ex_mem", ex_mem_out, 96'd0);
      checkOutput("reset stall_req", 96'(ex_stall_req), 96'd0);
      driveBubble();
      rst = 1'b0;
      tick();

      // Directed forwarding cases: rs1 = 5 plus imm -3, then from writeback, EX/MEM and reserved select.
      applyStimulus(ALU_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 5'd1, 2'b00, 2'b00, 32'd9);
      checkOutput("add no stall_req", 96'(ex_stall_req), 96'd0);
      tick();
      checkOutput("add imm", ex_mem_out.alu_result, 96'd2);
      applyStimulus(ALU_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 5'd1, 2'b10, 2'b00, 32'd9);
      tick();
      checkOutput("add fwd wb", ex_mem_out.alu_result, 96'd6);
      applyStimulus(ALU_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 5'd1, 2'b01, 2'b00, 32'd9);
      tick();
      checkOutput("add fwd exmem", ex_mem_out.alu_result, 96'd3);
      applyStimulus(ALU_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 5'd1, 2'b11, 2'b00, 32'd9);
      tick();
      checkOutput("add fwd reserved", ex_mem_out.alu_result, 96'd2);
      exp_res = 32'd2;

      for (int i = 0; i < 30; i++) begin
         op    = single_ops[$urandom_range(0, 10)];
         a_raw = $urandom;
         b_raw = $urandom;
         imm   = $urandom;
         wb    = $urandom;
         fa    = 2'($urandom_range(0, 3));
         fb    = 2'($urandom_range(0, 3));
         src   = 1'($urandom_range(0, 1));
         rd    = 5'($urandom);
         opa    = (fa == 2'b01) ? exp_res : (fa == 2'b10) ? wb : a_raw;
         fb_val = (fb == 2'b01) ? exp_res : (fb == 2'b10) ? wb : b_raw;
         opb    = src ? imm : fb_val;
         expv   = ref_alu(op, opa, opb);
         applyStimulus(op, a_raw, b_raw, imm, src, rd, fa, fb, wb);
         tick();
         checkOutput($sformatf("rand %s result", op.name()), ex_mem_out.alu_result, expv);
         checkOutput($sformatf("rand %s rs2", op.name()), ex_mem_out.rs2_data, fb_val);
         checkOutput($sformatf("rand %s rd/ctrl", op.name()), {ex_mem_out.rd, ex_mem_out.ctrl},
                     {rd, id_ex_in.ctrl});
         exp_res = expv;
      end

`ifdef RV32M_EN
      runMOp(ALU_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, 0, "div -7/2");
      runMOp(ALU_REM,   32'hFFFF_FFF9, 32'd2,         0, 0, 0, "rem -7/2");
      runMOp(ALU_DIVU,  32'd100,       32'd0,         0, 0, 0, "divu by 0");
      runMOp(ALU_REMU,  32'd100,       32'd0,         0, 0, 0, "remu by 0");
      runMOp(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div overflow");
      runMOp(ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "rem overflow");
      runMOp(ALU_DIV,   32'hFFFF_FFEC, 32'd0,         0, 0, 0, "div neg by 0");
      runMOp(ALU_MULH,  32'h8000_0000, 32'h8000_0000, 0, 0, 0, "mulh min*min");
      runMOp(ALU_MULHU, 32'hFFFF_FFFF, 32'd2,         0, 0, 0, "mulhu");
      runMOp(ALU_MUL,   32'd7,         32'hFFFF_FFFD, 0, 0, 3, "mul 7*-3 done stall");
      runMOp(ALU_DIVU,  32'hDEAD_BEEF, 32'd77,        5, 4, 0, "divu busy stall");
      runMOp(ALU_REM,   32'h1234_5678, 32'hFFFF_FF00, 0, 0, 3, "rem done stall");
      for (int i = 0; i < 8; i++) begin
         op    = m_ops[$urandom_range(0, 7)];
         a_raw = $urandom;
         b_raw = ($urandom_range(0, 1) == 1) ? xlen_t'($urandom_range(1, 300)) : xlen_t'($urandom);
         runMOp(op, a_raw, b_raw, 0, 0, 0, $sformatf("rand %s", op.name()));
      end
      abortMOp(ALU_DIV, 10, 1'b0, "flush mid div");
      abortMOp(ALU_DIV, 5,  1'b1, "reset mid div");
      runMOp(ALU_DIV, 32'd1000, 32'hFFFF_FFF9, 0, 0, 0, "div after abort");
`else
      for (int i = 0; i < 3; i++) begin
         op = (i == 0) ? ALU_MUL : (i == 1) ? ALU_DIV : ALU_REMU;
         rd = 5'($urandom);
         applyStimulus(op, $urandom, $urandom, 32'd0, 1'b0, rd, 2'd0, 2'd0, 32'd0);
         checkOutput($sformatf("%s no stall_req", op.name()), 96'(ex_stall_req), 96'd0);
         tick();
         checkOutput($sformatf("%s zero result", op.name()), ex_mem_out.alu_result, 96'd0);
         checkOutput($sformatf("%s rd/ctrl", op.name()), {ex_mem_out.rd, ex_mem_out.ctrl},
                     {rd, id_ex_in.ctrl});
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
